// File: rtl/filt_pkg.sv
// Shared definitions for the multi-channel hysteresis glitch filter:
// per-channel FSM state encoding and the minimum effective run length.
package filt_pkg;

  typedef enum logic [1:0] {
    ST0   = 2'd0,
    PEND1 = 2'd1,
    ST1   = 2'd2,
    PEND0 = 2'd3
  } state_t;

  localparam int MIN_LEN = 2;

endpackage

// File: rtl/filt_if.sv
// Bus bundle for filt_multi: raw inputs and run lengths in, filtered levels
// and per-channel event pulses out.
interface filt_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 4
);

  logic [CH-1:0]    i;
  logic [CNT_W-1:0] rise_len;
  logic [CNT_W-1:0] fall_len;
  logic [CH-1:0]    y;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic [CH-1:0]    glitch;

  modport master (
    output i, rise_len, fall_len,
    input  y, rise, fall, glitch
  );

  modport slave (
    input  i, rise_len, fall_len,
    output y, rise, fall, glitch
  );

endinterface

// File: rtl/filt_chan.sv
// One filter channel: optional two-flop synchroniser (FILT_SYNC_EN), 4-state
// hysteresis FSM with run counter, and registered rise/fall/glitch pulses.
module filt_chan
  import filt_pkg::*;
#(
  parameter int   CNT_W = 4,
  parameter logic INIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i,
  input  logic [CNT_W-1:0] rise_len,
  input  logic [CNT_W-1:0] fall_len,
  output logic             y,
  output logic             rise,
  output logic             fall,
  output logic             glitch
);

  localparam logic [CNT_W:0] MIN_EFF = (CNT_W+1)'(MIN_LEN);

  logic s;

`ifdef FILT_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{INIT}};
    else        sync <= {sync[0], i};
  end

  assign s = sync[1];
`else
  assign s = i;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             y_n, rise_n, fall_n, glitch_n;
  logic [CNT_W:0]   eff_rise, eff_fall, cnt_inc;

  // Lengths below the minimum are clamped; the extra bit keeps cnt+1 from wrapping.
  assign eff_rise = ({1'b0, rise_len} < MIN_EFF) ? MIN_EFF : {1'b0, rise_len};
  assign eff_fall = ({1'b0, fall_len} < MIN_EFF) ? MIN_EFF : {1'b0, fall_len};
  assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT ? ST1 : ST0;
      cnt    <= '0;
      y      <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      y      <= y_n;
      rise   <= rise_n;
      fall   <= fall_n;
      glitch <= glitch_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    y_n      = y;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    glitch_n = 1'b0;
    case (state)
      ST0: begin
        if (s) begin
          state_n = PEND1;
          cnt_n   = CNT_W'(1);
        end
      end
      PEND1: begin
        if (!s) begin
          state_n  = ST0;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt_inc >= eff_rise) begin
          state_n = ST1;
          cnt_n   = '0;
          y_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end
      end
      ST1: begin
        if (!s) begin
          state_n = PEND0;
          cnt_n   = CNT_W'(1);
        end
      end
      PEND0: begin
        if (s) begin
          state_n  = ST1;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt_inc >= eff_fall) begin
          state_n = ST0;
          cnt_n   = '0;
          y_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end
      end
      // Recover to the stable state that agrees with the current output.
      default: begin
        state_n = y ? ST1 : ST0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/filt_multi.sv
// Multi-channel hysteresis glitch filter top: fans the shared run lengths out
// to CH independent filt_chan instances. Optional synchroniser: FILT_SYNC_EN.
module filt_multi
  import filt_pkg::*;
#(
  parameter int          CH       = 4,
  parameter int          CNT_W    = 4,
  parameter logic [CH-1:0] INIT_VAL = {CH{1'b0}}
) (
  input logic  clk,
  input logic  rst_n,
  filt_if.slave bus
);

  logic [CH-1:0] y_w, rise_w, fall_w, glitch_w;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    filt_chan #(
      .CNT_W (CNT_W),
      .INIT  (INIT_VAL[g])
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i        (bus.i[g]),
      .rise_len (bus.rise_len),
      .fall_len (bus.fall_len),
      .y        (y_w[g]),
      .rise     (rise_w[g]),
      .fall     (fall_w[g]),
      .glitch   (glitch_w[g])
    );
  end

  assign bus.y      = y_w;
  assign bus.rise   = rise_w;
  assign bus.fall   = fall_w;
  assign bus.glitch = glitch_w;

endmodule

// File: tb/tb_filt_multi.sv
// Directed bench for filt_multi (CH=4, CNT_W=4, INIT_VAL=4'b0101); expected
// edges are hand-derived and shift by two cycles when FILT_SYNC_EN is defined.
module tb_filt_multi;

`ifdef FILT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  filt_if #(.CH(4), .CNT_W(4)) bus ();

  filt_multi #(
    .CH       (4),
    .CNT_W    (4),
    .INIT_VAL (4'b0101)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] pulses;
    rst_n        = 1'b0;
    bus.i        = 4'b0101;
    bus.rise_len = 4'd2;
    bus.fall_len = 4'd2;
    #2;
    checks++;
    if (bus.y !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL reset_y y=%b expected 0101", bus.y);
    end
    repeat (3) step();
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      pulses = {bus.rise, bus.fall, bus.glitch};
      checks++;
      if (bus.y !== 4'b0101 || pulses !== 12'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold n=%0d y=%b pulses=%b expected 0101/0", n, bus.y, pulses);
      end
    end
  endtask

  task automatic test_rise_glitch();
    logic ey, ep;
    bus.rise_len = 4'd10;
    bus.fall_len = 4'd2;
    bus.i[1]     = 1'b1;
    for (int n = 1; n <= LAT + 11; n++) begin
      step();
      ey = (n >= LAT + 10);
      ep = (n == LAT + 10);
      checks++;
      if (bus.y[1] !== ey || bus.rise[1] !== ep || bus.glitch[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rise10 n=%0d y=%b rise=%b glitch=%b expected y=%b rise=%b glitch=0",
                 n, bus.y[1], bus.rise[1], bus.glitch[1], ey, ep);
      end
    end
    bus.i[1] = 1'b0;
    for (int n = 1; n <= LAT + 2; n++) begin
      step();
      ey = (n < LAT + 2);
      ep = (n == LAT + 2);
      checks++;
      if (bus.y[1] !== ey || bus.fall[1] !== ep) begin
        errors++;
        $display("[TB] FAIL fall2 n=%0d y=%b fall=%b expected y=%b fall=%b",
                 n, bus.y[1], bus.fall[1], ey, ep);
      end
    end
    bus.i[1] = 1'b1;
    for (int n = 1; n <= LAT + 12; n++) begin
      step();
      ep = (n == LAT + 10);
      checks++;
      if (bus.y[1] !== 1'b0 || bus.rise[1] !== 1'b0 || bus.glitch[1] !== ep) begin
        errors++;
        $display("[TB] FAIL run9 n=%0d y=%b rise=%b glitch=%b expected y=0 rise=0 glitch=%b",
                 n, bus.y[1], bus.rise[1], bus.glitch[1], ep);
      end
      if (n == 9) bus.i[1] = 1'b0;
    end
  endtask

  task automatic test_asym();
    logic ey, ep;
    bus.rise_len = 4'd12;
    bus.fall_len = 4'd3;
    bus.i[3]     = 1'b1;
    for (int n = 1; n <= LAT + 12; n++) begin
      step();
      ey = (n == LAT + 12);
      ep = (n == LAT + 12);
      checks++;
      if (bus.y[3] !== ey || bus.rise[3] !== ep) begin
        errors++;
        $display("[TB] FAIL asym_rise n=%0d y=%b rise=%b expected y=%b rise=%b",
                 n, bus.y[3], bus.rise[3], ey, ep);
      end
    end
    bus.i[3] = 1'b0;
    for (int n = 1; n <= LAT + 3; n++) begin
      step();
      ey = (n < LAT + 3);
      ep = (n == LAT + 3);
      checks++;
      if (bus.y[3] !== ey || bus.fall[3] !== ep) begin
        errors++;
        $display("[TB] FAIL asym_fall n=%0d y=%b fall=%b expected y=%b fall=%b",
                 n, bus.y[3], bus.fall[3], ey, ep);
      end
    end
  endtask

  task automatic test_clamp();
    logic [3:0] lens [2];
    logic       ey, ep;
    lens[0] = 4'd0;
    lens[1] = 4'd1;
    for (int k = 0; k < 2; k++) begin
      bus.rise_len = lens[k];
      bus.fall_len = lens[k];
      bus.i[1]     = 1'b1;
      for (int n = 1; n <= LAT + 2; n++) begin
        step();
        ey = (n == LAT + 2);
        ep = (n == LAT + 2);
        checks++;
        if (bus.y[1] !== ey || bus.rise[1] !== ep) begin
          errors++;
          $display("[TB] FAIL clamp_rise len=%0d n=%0d y=%b rise=%b expected y=%b rise=%b",
                   lens[k], n, bus.y[1], bus.rise[1], ey, ep);
        end
      end
      bus.i[1] = 1'b0;
      for (int n = 1; n <= LAT + 2; n++) begin
        step();
        ey = (n < LAT + 2);
        ep = (n == LAT + 2);
        checks++;
        if (bus.y[1] !== ey || bus.fall[1] !== ep) begin
          errors++;
          $display("[TB] FAIL clamp_fall len=%0d n=%0d y=%b fall=%b expected y=%b fall=%b",
                   lens[k], n, bus.y[1], bus.fall[1], ey, ep);
        end
      end
    end
  endtask

  task automatic test_live_len();
    logic       ey, ep;
    logic [3:0] ey_v, er_v;
    bus.rise_len = 4'd15;
    bus.fall_len = 4'd2;
    bus.i[3]     = 1'b1;
    for (int n = 1; n <= LAT + 8; n++) begin
      step();
      ey = (n == LAT + 8);
      ep = (n == LAT + 8);
      checks++;
      if (bus.y[3] !== ey || bus.rise[3] !== ep) begin
        errors++;
        $display("[TB] FAIL live_len n=%0d y=%b rise=%b expected y=%b rise=%b",
                 n, bus.y[3], bus.rise[3], ey, ep);
      end
      if (n == LAT + 7) bus.rise_len = 4'd5;
    end
    // Channel 3 is high and channel 1 mid-count when reset hits.
    bus.rise_len = 4'd10;
    bus.i[1]     = 1'b1;
    repeat (LAT + 5) step();
    rst_n    = 1'b0;
    bus.i[3] = 1'b0;
    #2;
    checks++;
    if (bus.y !== 4'b0101 || {bus.rise, bus.fall, bus.glitch} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midreset y=%b pulses=%b expected 0101/0",
               bus.y, {bus.rise, bus.fall, bus.glitch});
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int n = 1; n <= LAT + 10; n++) begin
      step();
      ey_v = {1'b0, 1'b1, (n >= LAT + 10), 1'b1};
      er_v = {2'b00, (n == LAT + 10), 1'b0};
      checks++;
      if (bus.y !== ey_v || bus.rise !== er_v || {bus.fall, bus.glitch} !== 8'd0) begin
        errors++;
        $display("[TB] FAIL post_reset n=%0d y=%b rise=%b fall=%b glitch=%b expected y=%b rise=%b",
                 n, bus.y, bus.rise, bus.fall, bus.glitch, ey_v, er_v);
      end
    end
    bus.i[1]     = 1'b0;
    bus.fall_len = 4'd2;
    repeat (LAT + 3) step();
    checks++;
    if (bus.y !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL live_restore y=%b expected 0101", bus.y);
    end
  endtask

  task automatic test_multi();
    logic [3:0] ey, er, ef, eg;
    bus.rise_len = 4'd6;
    bus.fall_len = 4'd4;
    bus.i        = 4'b1010;
    for (int n = 1; n <= LAT + 8; n++) begin
      step();
      ey = {1'b0, 1'b1, (n >= LAT + 6), (n < LAT + 4)};
      er = {2'b00, (n == LAT + 6), 1'b0};
      ef = {3'b000, (n == LAT + 4)};
      eg = {(n == LAT + 4), (n == LAT + 3), 2'b00};
      checks++;
      if (bus.y !== ey || bus.rise !== er || bus.fall !== ef || bus.glitch !== eg) begin
        errors++;
        $display("[TB] FAIL multi n=%0d y=%b r=%b f=%b g=%b expected y=%b r=%b f=%b g=%b",
                 n, bus.y, bus.rise, bus.fall, bus.glitch, ey, er, ef, eg);
      end
      if (n == 2) bus.i[2] = 1'b1;
      if (n == 3) bus.i[3] = 1'b0;
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b1;
    checks       = 0;
    errors       = 0;
    bus.i        = 4'b0101;
    bus.rise_len = 4'd2;
    bus.fall_len = 4'd2;
    #1;
    test_reset();
    test_rise_glitch();
    test_asym();
    test_clamp();
    test_live_len();
    test_multi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
